// File: rtl/axi4_ram_master.sv
// axi4_ram_master: turns one outstanding load/store burst request into
// an AXI4 INCR transaction on the data RAM port and reports completion.
package axi_4_FULL_Types;
  typedef enum logic [1:0] {
    OKAY   = 2'd0,
    EXOKAY = 2'd1,
    SLVERR = 2'd2,
    DECERR = 2'd3
  } axi4_resp_el;

  typedef enum logic [1:0] {
    FIXED = 2'd0,
    INCR  = 2'd1,
    WRAP  = 2'd2,
    RSVD  = 2'd3
  } BURST;
endpackage

module axi4_ram_master
  import axi_4_FULL_Types::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int ID_WIDTH   = 4,
  parameter int MASTER_ID  = 0
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [7:0]              req_len,
  input  logic                    wd_valid,
  output logic                    wd_ready,
  input  logic [DATA_WIDTH-1:0]   wd_data,
  input  logic [DATA_WIDTH/8-1:0] wd_strb,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_last,
  output logic                    done,
  output logic                    done_err,
  output logic [ID_WIDTH-1:0]     AWID,
  output logic [ADDR_WIDTH-1:0]   AWADDR,
  output logic [7:0]              AWLEN,
  output logic [2:0]              AWSIZE,
  output BURST                    AWBURST,
  output logic [3:0]              AWCACHE,
  output logic [3:0]              AWQOS,
  output logic [3:0]              AWREGION,
  output logic                    AWVALID,
  input  logic                    AWREADY,
  output logic [DATA_WIDTH-1:0]   WDATA,
  output logic [DATA_WIDTH/8-1:0] WSTRB,
  output logic                    WLAST,
  output logic                    WVALID,
  input  logic                    WREADY,
  input  logic [ID_WIDTH-1:0]     BID,
  input  axi4_resp_el             BRESP,
  input  logic                    BVALID,
  output logic                    BREADY,
  output logic [ID_WIDTH-1:0]     ARID,
  output logic [ADDR_WIDTH-1:0]   ARADDR,
  output logic [7:0]              ARLEN,
  output logic [2:0]              ARSIZE,
  output BURST                    ARBURST,
  output logic [3:0]              ARCACHE,
  output logic [3:0]              ARQOS,
  output logic [3:0]              ARREGION,
  output logic                    ARVALID,
  input  logic                    ARREADY,
  input  logic [ID_WIDTH-1:0]     RID,
  input  logic [DATA_WIDTH-1:0]   RDATA,
  input  axi4_resp_el             RRESP,
  input  logic                    RLAST,
  input  logic                    RVALID,
  output logic                    RREADY
);

  localparam logic [ID_WIDTH-1:0] MID = ID_WIDTH'(MASTER_ID);
  localparam logic [ADDR_WIDTH-1:0] AMASK = ~ADDR_WIDTH'(3);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AR,
    ST_R,
    ST_AW,
    ST_W,
    ST_B,
    ST_DONE
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [7:0]              len_q, len_d;
  logic [7:0]              beat_q, beat_d;
  logic                    err_q, err_d;
  logic                    live_q;
  logic                    last;
  logic                    r_bad;
  logic                    b_bad;

  assign last = (beat_q == len_q);

  assign r_bad = (RRESP == SLVERR) || (RRESP == DECERR)
              || (RID != MID) || (RLAST != last);
  assign b_bad = (BRESP == SLVERR) || (BRESP == DECERR)
              || (BID != MID);

  assign AWID     = MID;
  assign AWADDR   = addr_q;
  assign AWLEN    = len_q;
  assign AWSIZE   = 3'd2;
  assign AWBURST  = INCR;
  assign AWCACHE  = 4'd0;
  assign AWQOS    = 4'd0;
  assign AWREGION = 4'd0;
  assign ARID     = MID;
  assign ARADDR   = addr_q;
  assign ARLEN    = len_q;
  assign ARSIZE   = 3'd2;
  assign ARBURST  = INCR;
  assign ARCACHE  = 4'd0;
  assign ARQOS    = 4'd0;
  assign ARREGION = 4'd0;
  assign WDATA    = wd_data;
  assign WSTRB    = wd_strb;
  assign rd_data  = RDATA;

  // State and request registers; live_q holds off req_ready one edge
  // past reset release.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      err_q   <= 1'b0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
      live_q  <= 1'b1;
    end
  end

  // Next state, beat counting, sticky error and handshake outputs.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    beat_d    = beat_q;
    err_d     = err_q;
    req_ready = 1'b0;
    AWVALID   = 1'b0;
    ARVALID   = 1'b0;
    WVALID    = 1'b0;
    WLAST     = 1'b0;
    wd_ready  = 1'b0;
    BREADY    = 1'b0;
    RREADY    = 1'b0;
    rd_valid  = 1'b0;
    rd_last   = 1'b0;
    done      = 1'b0;
    done_err  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        req_ready = live_q;
        if (live_q && req_valid) begin
          addr_d  = req_addr & AMASK;
          len_d   = req_len;
          beat_d  = '0;
          err_d   = 1'b0;
          state_d = req_write ? ST_AW : ST_AR;
        end
      end
      ST_AR: begin
        ARVALID = 1'b1;
        if (ARREADY) state_d = ST_R;
      end
      ST_R: begin
        RREADY   = rd_ready;
        rd_valid = RVALID;
        rd_last  = last;
        if (RVALID && rd_ready) begin
          beat_d = beat_q + 8'd1;
          if (r_bad) err_d = 1'b1;
          if (last) state_d = ST_DONE;
        end
      end
      ST_AW: begin
        AWVALID = 1'b1;
        if (AWREADY) state_d = ST_W;
      end
      ST_W: begin
        WVALID   = wd_valid;
        wd_ready = WREADY;
        WLAST    = last;
        if (wd_valid && WREADY) begin
          beat_d = beat_q + 8'd1;
          if (last) state_d = ST_B;
        end
      end
      ST_B: begin
        BREADY = 1'b1;
        if (BVALID) begin
          if (b_bad) err_d = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        done     = 1'b1;
        done_err = err_q;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi4_ram_master.sv
// tb_axi4_ram_master: randomized bench with a behavioural AXI RAM slave
// and a word-array reference of the RAM contents.
module tb_axi4_ram_master;
  import axi_4_FULL_Types::*;

  logic        ACLK, ARESETn;
  logic        req_valid, req_ready, req_write;
  logic [4:0]  req_addr;
  logic [7:0]  req_len;
  logic        wd_valid, wd_ready;
  logic [31:0] wd_data;
  logic [3:0]  wd_strb;
  logic        rd_valid, rd_ready, rd_last;
  logic [31:0] rd_data;
  logic        done, done_err;
  logic [3:0]  AWID, ARID, BID, RID;
  logic [4:0]  AWADDR, ARADDR;
  logic [7:0]  AWLEN, ARLEN;
  logic [2:0]  AWSIZE, ARSIZE;
  BURST        AWBURST, ARBURST;
  logic [3:0]  AWCACHE, AWQOS, AWREGION;
  logic [3:0]  ARCACHE, ARQOS, ARREGION;
  logic        AWVALID, AWREADY, ARVALID, ARREADY;
  logic [31:0] WDATA, RDATA;
  logic [3:0]  WSTRB;
  logic        WLAST, WVALID, WREADY;
  axi4_resp_el BRESP, RRESP;
  logic        BVALID, BREADY;
  logic        RLAST, RVALID, RREADY;

  axi4_ram_master dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr),
    .req_len(req_len),
    .wd_valid(wd_valid), .wd_ready(wd_ready),
    .wd_data(wd_data), .wd_strb(wd_strb),
    .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_data(rd_data), .rd_last(rd_last),
    .done(done), .done_err(done_err),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN),
    .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWCACHE(AWCACHE), .AWQOS(AWQOS),
    .AWREGION(AWREGION), .AWVALID(AWVALID),
    .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST),
    .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID),
    .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN),
    .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARCACHE(ARCACHE), .ARQOS(ARQOS),
    .ARREGION(ARREGION), .ARVALID(ARVALID),
    .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP),
    .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] d;
    axi4_resp_el r;
    logic        l;
  } rbeat_t;

  rbeat_t      rq[$];
  logic [31:0] smem [8];
  logic [31:0] rmem [8];
  logic [31:0] wdat [256];
  logic [3:0]  wstb [256];
  bit          slv_stall = 0;
  bit          inj_berr = 0;
  int          inj_rerr = -1;
  logic [4:0]  ar_seen_addr, aw_seen_addr;
  logic [7:0]  ar_seen_len, aw_seen_len;

  initial begin
    ACLK = 0;
    forever #5 ACLK = ~ACLK;
  end

  function automatic int widx(input int base, input int i);
    return ((base + 4 * i) % 32) / 4;
  endfunction

  // Behavioural slave: drives at negedge, samples handshakes 1ns later.
  initial begin
    int idx, w_beat, w_len, w_base;
    bit aw_act, b_pend, r_fired, b_fired;
    rbeat_t bt;
    aw_act = 0; b_pend = 0; r_fired = 0; b_fired = 0;
    w_beat = 0; w_len = 0; w_base = 0;
    AWREADY = 0; WREADY = 0; ARREADY = 0;
    BVALID = 0; BID = '0; BRESP = OKAY;
    RVALID = 0; RID = '0; RDATA = '0; RRESP = OKAY; RLAST = 0;
    forever begin
      @(negedge ACLK);
      if (!ARESETn) begin
        rq.delete();
        aw_act = 0; b_pend = 0; r_fired = 0; b_fired = 0;
        AWREADY = 0; WREADY = 0; ARREADY = 0;
        RVALID = 0; BVALID = 0;
      end else begin
        if (r_fired) begin
          void'(rq.pop_front());
          RVALID = 0; r_fired = 0;
        end
        if (b_fired) begin
          BVALID = 0; b_pend = 0; b_fired = 0; inj_berr = 0;
        end
        if (!RVALID && rq.size() != 0 &&
            (!slv_stall || $urandom_range(0, 1) == 1)) begin
          RVALID = 1; RDATA = rq[0].d;
          RRESP = rq[0].r; RLAST = rq[0].l;
        end
        if (!BVALID && b_pend &&
            (!slv_stall || $urandom_range(0, 1) == 1)) begin
          BVALID = 1;
          BRESP = inj_berr ? DECERR : OKAY;
        end
        ARREADY = !slv_stall || $urandom_range(0, 1) == 1;
        AWREADY = !slv_stall || $urandom_range(0, 1) == 1;
        WREADY  = !slv_stall || $urandom_range(0, 2) != 0;
        #1;
        if (WVALID && WREADY) begin
          checks++;
          if (!aw_act) begin
            errors++;
            $display("FAIL w_before_aw: WVALID=1 required 0");
          end else begin
            idx = widx(w_base, w_beat);
            for (int b = 0; b < 4; b++)
              if (WSTRB[b]) smem[idx][8*b +: 8] = WDATA[8*b +: 8];
            if (w_beat == w_len) begin
              aw_act = 0; b_pend = 1;
            end
            w_beat++;
          end
        end
        if (AWVALID && AWREADY) begin
          aw_act = 1; w_beat = 0;
          w_base = int'(AWADDR); w_len = int'(AWLEN);
          aw_seen_addr = AWADDR; aw_seen_len = AWLEN;
          checks++;
          if (AWSIZE !== 3'd2 || AWBURST !== INCR || AWID !== 4'd0 ||
              AWCACHE !== 4'd0 || AWQOS !== 4'd0 || AWREGION !== 4'd0) begin
            errors++;
            $display("FAIL aw_const: size=%0d burst=%0d id=%0d required 2/1/0",
                     AWSIZE, AWBURST, AWID);
          end
        end
        if (ARVALID && ARREADY) begin
          ar_seen_addr = ARADDR; ar_seen_len = ARLEN;
          checks++;
          if (ARSIZE !== 3'd2 || ARBURST !== INCR || ARID !== 4'd0 ||
              ARCACHE !== 4'd0 || ARQOS !== 4'd0 || ARREGION !== 4'd0) begin
            errors++;
            $display("FAIL ar_const: size=%0d burst=%0d id=%0d required 2/1/0",
                     ARSIZE, ARBURST, ARID);
          end
          for (int i = 0; i <= int'(ARLEN); i++) begin
            bt.d = smem[widx(int'(ARADDR), i)];
            bt.r = (i == inj_rerr) ? SLVERR : OKAY;
            bt.l = (i == int'(ARLEN));
            rq.push_back(bt);
          end
          inj_rerr = -1;
        end
        if (RVALID && RREADY) r_fired = 1;
        if (BVALID && BREADY) b_fired = 1;
      end
    end
  end

  task automatic issue(input bit wr, input logic [4:0] a,
                       input logic [7:0] l, output bit ok);
    int t = 0;
    @(negedge ACLK);
    req_valid = 1; req_write = wr; req_addr = a; req_len = l;
    #1;
    while (!req_ready && t < 50) begin
      @(negedge ACLK); #1; t++;
    end
    ok = req_ready;
    if (!ok) begin
      errors++; checks++;
      $display("FAIL req_accept: req_ready=0 required 1");
    end
    @(posedge ACLK); #1;
    req_valid = 0;
  endtask

  task automatic do_read(input logic [4:0] a, input logic [7:0] l,
                         input int rmode, input bit exp_err,
                         input string nm, output int dcyc);
    int beats = 0, cyc = 0, ba, idx;
    bit got = 0, ok, tog = 1;
    ba = (int'(a) / 4) * 4;
    dcyc = -1;
    ar_seen_addr = 'x; ar_seen_len = 'x;
    issue(0, a, l, ok);
    while (ok && !got && cyc < 3000) begin
      @(negedge ACLK); cyc++;
      case (rmode)
        0: rd_ready = 1;
        1: rd_ready = tog;
        default: rd_ready = ($urandom_range(0, 1) == 1);
      endcase
      tog = !tog;
      #1;
      if (rmode == 1 && RVALID) begin
        checks++;
        if (RREADY !== rd_ready) begin
          errors++;
          $display("FAIL %s rready: %b required %b", nm, RREADY, rd_ready);
        end
      end
      if (rd_valid && rd_ready) begin
        idx = widx(ba, beats);
        checks++;
        if (rd_data !== rmem[idx] || rd_last !== (beats == int'(l))) begin
          errors++;
          $display("FAIL %s beat %0d: data=%h last=%b required %h %b",
                   nm, beats, rd_data, rd_last, rmem[idx], beats == int'(l));
        end
        beats++;
      end
      if (done) begin
        got = 1; dcyc = cyc;
        checks++;
        if (beats != int'(l) + 1 || done_err !== exp_err) begin
          errors++;
          $display("FAIL %s done: beats=%0d err=%b required %0d %b",
                   nm, beats, done_err, int'(l) + 1, exp_err);
        end
      end
    end
    @(negedge ACLK); rd_ready = 0; #1;
    checks++;
    if (!got || done !== 1'b0) begin
      errors++;
      $display("FAIL %s done_pulse: got=%b done=%b required 1 0",
               nm, got, done);
    end
    checks++;
    if (ar_seen_addr !== 5'(ba) || ar_seen_len !== l) begin
      errors++;
      $display("FAIL %s ar: addr=%0d len=%0d required %0d %0d",
               nm, ar_seen_addr, ar_seen_len, ba, l);
    end
  endtask

  task automatic do_write(input logic [4:0] a, input logic [7:0] l,
                          input bit gaps, input bit exp_err,
                          input string nm);
    int beats = 0, cyc = 0, ba, idx;
    bit got = 0, ok, saw_b = 0;
    ba = (int'(a) / 4) * 4;
    aw_seen_addr = 'x; aw_seen_len = 'x;
    issue(1, a, l, ok);
    while (ok && !got && cyc < 3000) begin
      @(negedge ACLK); cyc++;
      wd_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      wd_data = wdat[8'(beats)];
      wd_strb = wstb[8'(beats)];
      #1;
      if (BREADY) saw_b = 1;
      if (wd_valid && wd_ready) begin
        checks++;
        if (WLAST !== (beats == int'(l)) || WVALID !== 1'b1) begin
          errors++;
          $display("FAIL %s wlast beat %0d: %b required %b",
                   nm, beats, WLAST, beats == int'(l));
        end
        idx = widx(ba, beats);
        for (int b = 0; b < 4; b++)
          if (wd_strb[b]) rmem[idx][8*b +: 8] = wd_data[8*b +: 8];
        beats++;
      end
      if (done) begin
        got = 1;
        checks++;
        if (beats != int'(l) + 1 || !saw_b || done_err !== exp_err) begin
          errors++;
          $display("FAIL %s done: beats=%0d bready=%b err=%b required %0d 1 %b",
                   nm, beats, saw_b, done_err, int'(l) + 1, exp_err);
        end
      end
    end
    @(negedge ACLK); wd_valid = 0; #1;
    checks++;
    if (!got || done !== 1'b0) begin
      errors++;
      $display("FAIL %s done_pulse: got=%b done=%b required 1 0",
               nm, got, done);
    end
    checks++;
    if (aw_seen_addr !== 5'(ba) || aw_seen_len !== l) begin
      errors++;
      $display("FAIL %s aw: addr=%0d len=%0d required %0d %0d",
               nm, aw_seen_addr, aw_seen_len, ba, l);
    end
  endtask

  task automatic test_reset();
    ARESETn = 1; #1; ARESETn = 0;
    repeat (2) @(negedge ACLK);
    #1;
    checks++;
    if (req_ready !== 0 || AWVALID !== 0 || ARVALID !== 0 ||
        WVALID !== 0 || WLAST !== 0 || BREADY !== 0 || RREADY !== 0 ||
        wd_ready !== 0 || rd_valid !== 0 || rd_last !== 0 ||
        done !== 0 || done_err !== 0) begin
      errors++;
      $display("FAIL reset_ctrl: rdy=%b awv=%b arv=%b done=%b required 0",
               req_ready, AWVALID, ARVALID, done);
    end
    checks++;
    if (ARADDR !== 5'd0 || AWADDR !== 5'd0 || ARLEN !== 8'd0 ||
        AWLEN !== 8'd0 || ARBURST !== INCR || AWBURST !== INCR) begin
      errors++;
      $display("FAIL reset_fields: araddr=%0d arlen=%0d arburst=%0d required 0 0 1",
               ARADDR, ARLEN, ARBURST);
    end
    #2 ARESETn = 1; #1;
    checks++;
    if (req_ready !== 0) begin
      errors++;
      $display("FAIL reset_release: req_ready=%b required 0", req_ready);
    end
    @(posedge ACLK); #1;
    checks++;
    if (req_ready !== 1) begin
      errors++;
      $display("FAIL reset_ready: req_ready=%b required 1", req_ready);
    end
  endtask

  task automatic test_min_read();
    int d;
    do_read(5'd4, 8'd0, 0, 0, "min_read", d);
    checks++;
    if (d != 3) begin
      errors++;
      $display("FAIL min_read_latency: %0d cycles required 3", d);
    end
  endtask

  task automatic test_read_basic();
    int d;
    do_read(5'd4, 8'd3, 0, 0, "read4", d);
  endtask

  task automatic test_write_gaps();
    int d;
    wdat[0] = 32'hA5A5_0001; wdat[1] = 32'hA5A5_0002;
    wstb[0] = 4'hF; wstb[1] = 4'hF;
    do_write(5'd8, 8'd1, 1, 0, "write_gaps");
    do_read(5'd8, 8'd1, 0, 0, "readback", d);
  endtask

  task automatic test_toggle();
    int d;
    do_read(5'd0, 8'd7, 1, 0, "toggle", d);
  endtask

  task automatic test_err();
    int d;
    inj_rerr = 1;
    do_read(5'd12, 8'd2, 0, 1, "rresp_err", d);
    do_read(5'd12, 8'd2, 0, 0, "after_rerr", d);
    inj_berr = 1;
    for (int i = 0; i < 2; i++) begin
      wdat[i] = $urandom; wstb[i] = 4'hF;
    end
    do_write(5'd20, 8'd1, 0, 1, "bresp_err");
    do_write(5'd20, 8'd1, 0, 0, "after_berr");
  endtask

  task automatic test_random();
    int d;
    logic [4:0] a;
    logic [7:0] l;
    slv_stall = 1;
    for (int t = 0; t < 24; t++) begin
      a = 5'($urandom_range(0, 31));
      l = 8'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < 16; i++) begin
          wdat[i] = $urandom; wstb[i] = 4'($urandom);
        end
        do_write(a, l, 1, 0, "rand_wr");
      end else begin
        do_read(a, l, 2, 0, "rand_rd", d);
      end
    end
    slv_stall = 0;
  endtask

  task automatic test_unaligned();
    int d;
    do_read(5'd5, 8'd0, 0, 0, "unaligned", d);
  endtask

  task automatic test_reset_mid_write();
    bit ok;
    int c = 0, d;
    for (int i = 0; i < 4; i++) begin
      wdat[i] = $urandom; wstb[i] = 4'hF;
    end
    issue(1, 5'd16, 8'd3, ok);
    wd_valid = 1; wd_data = wdat[0]; wd_strb = 4'hF;
    do begin
      @(negedge ACLK); #1; c++;
    end while (!WVALID && c < 20);
    checks++;
    if (WVALID !== 1) begin
      errors++;
      $display("FAIL rst_reach_w: WVALID=%b required 1", WVALID);
    end
    #2 ARESETn = 0; #1;
    checks++;
    if (WVALID !== 0 || BREADY !== 0 || done !== 0 ||
        req_ready !== 0 || wd_ready !== 0 || AWVALID !== 0) begin
      errors++;
      $display("FAIL rst_async: wv=%b br=%b done=%b rdy=%b required 0",
               WVALID, BREADY, done, req_ready);
    end
    wd_valid = 0;
    @(negedge ACLK);
    #3 ARESETn = 1;
    @(posedge ACLK); #1;
    checks++;
    if (req_ready !== 1 || done !== 0) begin
      errors++;
      $display("FAIL rst_recover: rdy=%b done=%b required 1 0",
               req_ready, done);
    end
    do_read(5'd0, 8'd3, 0, 0, "post_reset_rd", d);
  endtask

  initial begin
    req_valid = 0; req_write = 0; req_addr = '0; req_len = '0;
    wd_valid = 0; wd_data = '0; wd_strb = '0; rd_ready = 0;
    for (int i = 0; i < 8; i++) begin
      smem[i] = $urandom;
      rmem[i] = smem[i];
    end
    test_reset();
    test_min_read();
    test_read_basic();
    test_write_gaps();
    test_toggle();
    test_err();
    test_random();
    test_unaligned();
    test_reset_mid_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi4_ram_master.md
# axi4_ram_master

AXI4 full master that converts single-outstanding burst requests from the core-side load/store unit into AXI4 INCR transactions on the data RAM slave port. It sits directly upstream of the AXI4 data RAM. It generates AR/AW/W handshakes, counts beats and produces WLAST. It returns read beats and a per-transaction completion status to the requester.

## Interface
- DATA_WIDTH, 32, data bus width; strobe width is DATA_WIDTH/8.
- ADDR_WIDTH, 5, byte address width; matches the RAM's AxADDR.
- ID_WIDTH, 4, AXI ID width.
- MASTER_ID, 0, constant driven on AWID/ARID and expected on RID/BID.

Ports:
- ACLK  in  1  clock; all logic on rising edge.
- ARESETn  in  1  asynchronous, active-low reset.
- req_valid / req_ready  in / out  1 / 1  request handshake.
- req_write  in  1  1 = write burst, 0 = read burst.
- req_addr  in  ADDR_WIDTH  start byte address; bits [1:0] are ignored and driven as 0.
- req_len  in  8  beats minus 1 (0..255).
- wd_valid / wd_ready / wd_data / wd_strb  in / out / in / in  1 / 1 / DATA_WIDTH / DATA_WIDTH/8  write-data stream.
- rd_valid / rd_ready / rd_data / rd_last  out / in / out / out  1 / 1 / DATA_WIDTH / 1  read-data stream.
- done  out  1  one-cycle completion pulse.
- done_err  out  1  valid with done; 1 = error in transaction.
- AXI AW: AWID, AWADDR, AWLEN, AWSIZE, AWBURST (BURST), AWCACHE, AWQOS, AWREGION, AWVALID out; AWREADY in.
- AXI W: WDATA, WSTRB, WLAST, WVALID out; WREADY in.
- AXI B: BID, BRESP (axi4_resp_el), BVALID in; BREADY out.
- AXI AR: ARID, ARADDR, ARLEN, ARSIZE, ARBURST (BURST), ARCACHE, ARQOS, ARREGION, ARVALID out; ARREADY in.
- AXI R: RID, RDATA, RRESP (axi4_resp_el), RLAST, RVALID in; RREADY out.
- Types come from the axi_4_FULL_Types package.

## Operation
- FSM states: IDLE, AR, R, AW, W, B, DONE.
- IDLE:
  - req_ready = 1.
  - On req_valid, latch addr/len/write, clear err, clear beat_cnt.
  - Next state is AW if req_write, else AR.
- AR: ARVALID = 1 with registered fields; hold them stable until ARREADY; then go to R.
- R:
  - RREADY = rd_ready; rd_valid = RVALID; rd_data = RDATA.
  - rd_last = (beat_cnt == len).
  - Each R handshake increments beat_cnt (8-bit).
  - Final beat (beat_cnt == len) goes to DONE.
- AW: AWVALID = 1; hold fields until AWREADY; then go to W. W beats are never issued before the AW handshake.
- W:
  - WVALID = wd_valid; wd_ready = WREADY; WDATA/WSTRB pass through.
  - WLAST = (beat_cnt == len).
  - The final W handshake goes to B.
- B: BREADY = 1; the BVALID handshake goes to DONE.
- DONE: done = 1 and done_err = err for exactly one cycle, then IDLE.
- Constant fields: AxSIZE = 3'd2, AxBURST = INCR, AxCACHE = 0, AxQOS = 0, AxREGION = 0, AxLEN = latched len, AxID = MASTER_ID.
- Response encoding: OKAY = 0, EXOKAY = 1, SLVERR = 2, DECERR = 3.
- err is sticky within a transaction and is set by any of:
  - RRESP or BRESP equal to SLVERR or DECERR;
  - RID or BID differing from MASTER_ID;
  - RLAST differing from (beat_cnt == len) on any R handshake.
- The transaction ends on the counted final beat regardless of RLAST.
- Outside their states, every valid/ready output is 0.
- wd_ready = 0 outside W, so write data stalls upstream.

## Timing
- Reset values: all VALID/READY outputs 0, WLAST 0, done 0, done_err 0, rd_valid 0, rd_last 0, req_ready 0. Address/len fields are 0, AxBURST = INCR, FSM in IDLE.
- req_ready rises on the first ACLK edge after ARESETn deasserts.
- A request accepted at edge N drives AxVALID from edge N+1, registered.
- Read pass-through (R to rd_* and rd_ready to RREADY) is combinational, with zero added latency.
- Write pass-through (wd_* to W and WREADY to wd_ready) is combinational, with zero added latency.
- Minimum read of len = 0 with the slave always ready: request at N, AR handshake at N+1, R beat at N+2 or later, done one cycle after the last beat.
- AxVALID stays high until its READY is sampled; AxVALID never depends combinationally on READY.
- Reset mid-transaction: all outputs return to reset values asynchronously, the FSM returns to IDLE, and no done pulse is issued. The slave must also be reset.
- beat_cnt never wraps within a transaction, since len ≤ 255.

## Test plan
- Read, req_addr = 5'd4, req_len = 3, RAM preloaded, rd_ready = 1 → ARADDR = 4 and ARLEN = 3. Exactly 4 rd_valid beats occur, with rd_last only on the 4th. Then done = 1 and done_err = 0.
- Write, req_addr = 5'd8, req_len = 1, wd_data = 32'hA5A5_0001/0002, wd_strb = 4'hF, with wd_valid gaps inserted → WLAST only on the 2nd beat, BREADY after it, done with done_err = 0. A subsequent read of the same address returns both words.
- Read with rd_ready toggled every other cycle → RREADY mirrors rd_ready, no beat is lost or duplicated, and the data order is preserved.
- Slave returns RRESP = SLVERR on beat 1 of a 3-beat read → all 3 beats are still consumed and done_err = 1. The next clean request yields done_err = 0.
- ARESETn pulsed low during W state of a 4-beat write → WVALID, BREADY and done go to 0 immediately, req_ready returns to 1 after release, and a new read completes normally.
- req_addr = 5'd5 (unaligned) → ARADDR = 5'd4.
